// File: rtl/vuart_csr_mc.sv
// vuart_csr_mc: multi-channel CSR bank for the virtual UART subsystem.
// Each channel owns a 64-byte window selected by addr[HI_ADDR_BIT:6].
// Per channel: ID, CTRL, STATUS, INT_STAT (W1C), INT_EN and SCRATCH.
//
// Ports
//   clk_csr, rst_csr            clock, synchronous active-high reset
//   csr_write/waddr/write_type  write request; type 01=LOWER32, 10=UPPER32,
//   csr_wdata/wstrb             11=FULL64, 00=no write
//   csr_read/raddr              read request, may issue every cycle
//   csr_readdata(_valid)        read data, valid RD_LATENCY cycles after accept
//   ch_status_i                 live status per channel (32 b each)
//   ch_event_i                  event pulses per channel (8 b each)
//   ch_ctrl_o                   CTRL contents per channel (32 b each)
//   ch_irq_o                    per-channel interrupt, registered
module vuart_csr_mc #(
   parameter int          NUM_CH      = 2,
   parameter int          DATA_WIDTH  = 64,
   parameter int          HI_ADDR_BIT = 9,
   parameter int          RD_LATENCY  = 4,
   parameter logic [15:0] VERSION     = 16'h0002
) (
   input  logic                    clk_csr,
   input  logic                    rst_csr,
   input  logic                    csr_write,
   input  logic [HI_ADDR_BIT:0]    csr_waddr,
   input  logic [1:0]              csr_write_type,
   input  logic [DATA_WIDTH-1:0]   csr_wdata,
   input  logic [7:0]              csr_wstrb,
   input  logic                    csr_read,
   input  logic [HI_ADDR_BIT:0]    csr_raddr,
   output logic [DATA_WIDTH-1:0]   csr_readdata,
   output logic                    csr_readdata_valid,
   input  logic [NUM_CH*32-1:0]    ch_status_i,
   input  logic [NUM_CH*8-1:0]     ch_event_i,
   output logic [NUM_CH*32-1:0]    ch_ctrl_o,
   output logic [NUM_CH-1:0]       ch_irq_o
);

   localparam int CH_W = HI_ADDR_BIT - 5;

   localparam logic [1:0] WT_LOWER32 = 2'b01;
   localparam logic [1:0] WT_UPPER32 = 2'b10;
   localparam logic [1:0] WT_FULL64  = 2'b11;

   localparam logic [2:0] OFF_ID       = 3'd0;
   localparam logic [2:0] OFF_CTRL     = 3'd1;
   localparam logic [2:0] OFF_STATUS   = 3'd2;
   localparam logic [2:0] OFF_INT_STAT = 3'd3;
   localparam logic [2:0] OFF_INT_EN   = 3'd4;
   localparam logic [2:0] OFF_SCRATCH  = 3'd5;

   function automatic logic [63:0] be_merge(input logic [63:0] old_v,
                                            input logic [63:0] new_v,
                                            input logic [7:0]  be);
      logic [63:0] r;
      for (int b = 0; b < 8; b++)
         r[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      return r;
   endfunction

   logic unused_addr_bits;
   assign unused_addr_bits = ^{csr_raddr[2:0], csr_waddr[2:0]};

   // write request stage
   logic            wr_vld_q;
   logic [CH_W-1:0] wr_ch_q;
   logic [2:0]      wr_off_q;
   logic [63:0]     wr_data_q;
   logic [7:0]      wr_be_q;
   logic [7:0]      type_mask;

   always_comb begin
      case (csr_write_type)
         WT_LOWER32: type_mask = 8'h0F;
         WT_UPPER32: type_mask = 8'hF0;
         WT_FULL64:  type_mask = 8'hFF;
         default:    type_mask = 8'h00;
      endcase
   end

   always_ff @(posedge clk_csr) begin
      if (rst_csr) begin
         wr_vld_q  <= 1'b0;
         wr_ch_q   <= '0;
         wr_off_q  <= '0;
         wr_data_q <= '0;
         wr_be_q   <= '0;
      end else begin
         wr_vld_q  <= csr_write;
         wr_ch_q   <= csr_waddr[HI_ADDR_BIT:6];
         wr_off_q  <= csr_waddr[5:3];
         wr_data_q <= csr_wdata;
         wr_be_q   <= csr_wstrb & type_mask;
      end
   end

   // register bank
   logic [31:0] ctrl_q     [NUM_CH];
   logic [7:0]  int_stat_q [NUM_CH];
   logic [7:0]  int_en_q   [NUM_CH];
   logic [63:0] scratch_q  [NUM_CH];
   logic [31:0] ctrl_d     [NUM_CH];
   logic [7:0]  int_stat_d [NUM_CH];
   logic [7:0]  int_en_d   [NUM_CH];
   logic [63:0] scratch_d  [NUM_CH];
   logic [7:0]  int_clr    [NUM_CH];
   logic [NUM_CH-1:0] wr_hit;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         wr_hit[c]  = wr_vld_q && (wr_ch_q == CH_W'(c));
         ctrl_d[c]    = ctrl_q[c];
         int_en_d[c]  = int_en_q[c];
         scratch_d[c] = scratch_q[c];
         int_clr[c]   = 8'h00;
         if (wr_hit[c]) begin
            case (wr_off_q)
               OFF_CTRL:     ctrl_d[c]    = 32'(be_merge({32'h0, ctrl_q[c]}, wr_data_q, wr_be_q));
               OFF_INT_STAT: int_clr[c]   = wr_be_q[0] ? wr_data_q[7:0] : 8'h00;
               OFF_INT_EN:   int_en_d[c]  = 8'(be_merge({56'h0, int_en_q[c]}, wr_data_q, wr_be_q));
               OFF_SCRATCH:  scratch_d[c] = be_merge(scratch_q[c], wr_data_q, wr_be_q);
               default: ;
            endcase
         end
         // a same-cycle event outranks the clear
         int_stat_d[c] = (int_stat_q[c] & ~int_clr[c]) | ch_event_i[c*8 +: 8];
      end
   end

   always_ff @(posedge clk_csr) begin
      if (rst_csr) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ctrl_q[c]     <= '0;
            int_stat_q[c] <= '0;
            int_en_q[c]   <= '0;
            scratch_q[c]  <= '0;
         end
         ch_irq_o <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            ctrl_q[c]     <= ctrl_d[c];
            int_stat_q[c] <= int_stat_d[c];
            int_en_q[c]   <= int_en_d[c];
            scratch_q[c]  <= scratch_d[c];
            ch_irq_o[c]   <= |(int_stat_q[c] & int_en_q[c]);
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ctrl
      assign ch_ctrl_o[g*32 +: 32] = ctrl_q[g];
   end

   // Read path. The bank is captured at the accepting edge, which places the
   // sample before a commit from a write accepted one cycle earlier; this
   // gives the documented ordering: reads accepted at N or N+1 relative to a
   // write see the old value, N+2 onwards see the new one.
   logic [CH_W-1:0] rd_ch;
   logic [2:0]      rd_off;
   logic [63:0]     rd_word;

   assign rd_ch  = csr_raddr[HI_ADDR_BIT:6];
   assign rd_off = csr_raddr[5:3];

   always_comb begin
      rd_word = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_ch == CH_W'(c)) begin
            case (rd_off)
               OFF_ID:       rd_word = {32'h0, VERSION, 8'h0, 8'(c)};
               OFF_CTRL:     rd_word = {32'h0, ctrl_q[c]};
               OFF_STATUS:   rd_word = {32'h0, ch_status_i[c*32 +: 32]};
               OFF_INT_STAT: rd_word = {56'h0, int_stat_q[c]};
               OFF_INT_EN:   rd_word = {56'h0, int_en_q[c]};
               OFF_SCRATCH:  rd_word = scratch_q[c];
               default: ;
            endcase
         end
      end
   end

   logic [63:0]           rd_pipe [RD_LATENCY-1];
   logic [RD_LATENCY-2:0] rd_vld;

   always_ff @(posedge clk_csr) begin
      if (rst_csr) begin
         for (int k = 0; k < RD_LATENCY-1; k++) rd_pipe[k] <= '0;
         rd_vld             <= '0;
         csr_readdata       <= '0;
         csr_readdata_valid <= 1'b0;
      end else begin
         rd_pipe[0] <= rd_word;
         rd_vld[0]  <= csr_read;
         for (int k = 1; k < RD_LATENCY-1; k++) begin
            rd_pipe[k] <= rd_pipe[k-1];
            rd_vld[k]  <= rd_vld[k-1];
         end
         csr_readdata_valid <= rd_vld[RD_LATENCY-2];
         if (rd_vld[RD_LATENCY-2]) csr_readdata <= rd_pipe[RD_LATENCY-2];
      end
   end

endmodule

// File: tb/tb_vuart_csr_mc.sv
module tb_vuart_csr_mc;

   localparam int L = 4;
   localparam logic [1:0] T_NONE = 2'b00, T_LO = 2'b01, T_HI = 2'b10, T_FULL = 2'b11;

   logic        clk_csr = 1'b0;
   logic        rst_csr = 1'b1;
   logic        csr_write = 1'b0;
   logic [9:0]  csr_waddr = '0;
   logic [1:0]  csr_write_type = '0;
   logic [63:0] csr_wdata = '0;
   logic [7:0]  csr_wstrb = '0;
   logic        csr_read = 1'b0;
   logic [9:0]  csr_raddr = '0;
   logic [63:0] csr_readdata;
   logic        csr_readdata_valid;
   logic [63:0] ch_status_i = '0;
   logic [15:0] ch_event_i = '0;
   logic [63:0] ch_ctrl_o;
   logic [1:0]  ch_irq_o;

   vuart_csr_mc #(.NUM_CH(2), .DATA_WIDTH(64), .HI_ADDR_BIT(9), .RD_LATENCY(L),
                  .VERSION(16'h0002)) dut (
      .clk_csr(clk_csr), .rst_csr(rst_csr),
      .csr_write(csr_write), .csr_waddr(csr_waddr), .csr_write_type(csr_write_type),
      .csr_wdata(csr_wdata), .csr_wstrb(csr_wstrb),
      .csr_read(csr_read), .csr_raddr(csr_raddr),
      .csr_readdata(csr_readdata), .csr_readdata_valid(csr_readdata_valid),
      .ch_status_i(ch_status_i), .ch_event_i(ch_event_i),
      .ch_ctrl_o(ch_ctrl_o), .ch_irq_o(ch_irq_o));

   always #5 clk_csr = ~clk_csr;

   int cyc = 0;
   always @(posedge clk_csr) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] data;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic w, input logic [9:0] wa, input logic [1:0] wt,
                        input logic [63:0] wd, input logic [7:0] ws,
                        input logic r, input logic [9:0] ra, input logic [63:0] ex,
                        input logic [15:0] ev);
      exp_t e;
      @(negedge clk_csr);
      csr_write = w; csr_waddr = wa; csr_write_type = wt; csr_wdata = wd; csr_wstrb = ws;
      csr_read = r; csr_raddr = ra; ch_event_i = ev;
      if (r) begin
         e.data = ex;
         e.due  = cyc + L;
         exp_q.push_back(e);
      end
   endtask

   task automatic wr(input logic [9:0] a, input logic [1:0] t, input logic [63:0] d, input logic [7:0] s);
      drive(1'b1, a, t, d, s, 1'b0, '0, '0, '0);
   endtask

   task automatic rd(input logic [9:0] a, input logic [63:0] ex);
      drive(1'b0, '0, T_NONE, '0, '0, 1'b1, a, ex, '0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, T_NONE, '0, '0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         forever begin
            exp_t e;
            @(negedge clk_csr);
            if (!rst_csr && csr_readdata_valid) begin
               n_chk++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_valid: got data %h with nothing outstanding", csr_readdata);
               end else begin
                  e = exp_q.pop_front();
                  if (csr_readdata !== e.data || cyc != e.due) begin
                     n_err++;
                     $display("FAIL read_data: got %h at cycle %0d expected %h at cycle %0d",
                              csr_readdata, cyc, e.data, e.due);
                  end
               end
            end
         end
      join_none

      // reset state
      idle(3);
      chk("rst_readdata", csr_readdata, 64'h0);
      chk("rst_valid", {63'h0, csr_readdata_valid}, 64'h0);
      chk("rst_ctrl_o", ch_ctrl_o, 64'h0);
      chk("rst_irq", {62'h0, ch_irq_o}, 64'h0);
      @(negedge clk_csr);
      rst_csr = 1'b0;
      idle(2);

      // SCRATCH full write and latency
      wr(10'h068, T_FULL, 64'hDEAD_BEEF_0123_4567, 8'hFF);
      idle(1);
      rd(10'h068, 64'hDEAD_BEEF_0123_4567);
      idle(6);
      chk("readdata_hold", csr_readdata, 64'hDEAD_BEEF_0123_4567);

      // write-type masking on ch0 SCRATCH
      wr(10'h028, T_LO, 64'hFFFF_FFFF_AAAA_5555, 8'hFF);
      idle(1);
      rd(10'h028, 64'h0000_0000_AAAA_5555);
      wr(10'h028, T_HI, 64'h1111_2222_3333_4444, 8'hFF);
      idle(1);
      rd(10'h028, 64'h1111_2222_AAAA_5555);
      wr(10'h028, T_NONE, 64'h0, 8'hFF);
      idle(1);
      rd(10'h028, 64'h1111_2222_AAAA_5555);
      wr(10'h028, T_FULL, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
      idle(1);
      rd(10'h028, 64'h1111_2222_AAAA_55FF);
      idle(6);

      // interrupts on ch0
      wr(10'h020, T_FULL, 64'h4, 8'hFF);
      idle(2);
      drive(1'b0, '0, T_NONE, '0, '0, 1'b0, '0, '0, 16'h0004);
      idle(1);
      chk("irq_not_yet", {62'h0, ch_irq_o}, 64'h0);
      idle(1);
      chk("irq_set", {62'h0, ch_irq_o}, 64'h1);
      rd(10'h018, 64'h04);
      wr(10'h018, T_FULL, 64'h4, 8'hFF);
      drive(1'b0, '0, T_NONE, '0, '0, 1'b0, '0, '0, 16'h0004);
      idle(1);
      chk("irq_hold_a", {62'h0, ch_irq_o}, 64'h1);
      idle(1);
      chk("irq_hold_b", {62'h0, ch_irq_o}, 64'h1);
      rd(10'h018, 64'h04);
      wr(10'h018, T_FULL, 64'h0, 8'hFF);
      idle(3);
      rd(10'h018, 64'h04);
      wr(10'h018, T_FULL, 64'h4, 8'h00);
      idle(3);
      rd(10'h018, 64'h04);
      wr(10'h018, T_FULL, 64'h4, 8'hFF);
      idle(1);
      chk("irq_clr_a", {62'h0, ch_irq_o}, 64'h1);
      idle(1);
      chk("irq_clr_b", {62'h0, ch_irq_o}, 64'h1);
      idle(1);
      chk("irq_clr_c", {62'h0, ch_irq_o}, 64'h0);
      rd(10'h018, 64'h00);
      idle(6);

      // back-to-back ID / unmapped reads
      rd(10'h000, {32'h0, 16'h0002, 8'h0, 8'h00});
      rd(10'h040, {32'h0, 16'h0002, 8'h0, 8'h01});
      rd(10'h0C8, 64'h0);
      idle(6);

      // same-cycle write and read of CTRL
      drive(1'b1, 10'h008, T_FULL, 64'h5A, 8'hFF, 1'b1, 10'h008, 64'h0, '0);
      idle(1);
      chk("ctrl_o_before", ch_ctrl_o, 64'h0);
      idle(1);
      chk("ctrl_o_after", ch_ctrl_o, 64'h0000_0000_0000_005A);
      rd(10'h008, 64'h5A);

      // write at N, reads at N+1 and N+2 on ch1 CTRL
      wr(10'h048, T_FULL, 64'hFFFF_FFFF_0000_0077, 8'hFF);
      rd(10'h048, 64'h0);
      rd(10'h048, 64'h77);
      idle(6);
      chk("ctrl_o_ch1", ch_ctrl_o, 64'h0000_0077_0000_005A);

      // status, reserved, unmapped writes
      ch_status_i = 64'hCAFE_0001_1234_5678;
      wr(10'h038, T_FULL, 64'h1234, 8'hFF);
      wr(10'h0E8, T_FULL, 64'h9999, 8'hFF);
      idle(1);
      rd(10'h050, 64'h0000_0000_CAFE_0001);
      rd(10'h010, 64'h0000_0000_1234_5678);
      rd(10'h038, 64'h0);
      rd(10'h0E8, 64'h0);
      rd(10'h06F, 64'hDEAD_BEEF_0123_4567);
      idle(8);
      chk("queue_drained_1", 64'(exp_q.size()), 64'h0);

      // reset with a read in flight
      @(negedge clk_csr);
      csr_read = 1'b1; csr_raddr = 10'h068;
      idle(1);
      @(negedge clk_csr);
      rst_csr = 1'b1;
      ch_event_i = 16'hFFFF;
      idle(1);
      ch_event_i = 16'hFFFF;
      @(negedge clk_csr);
      chk("rst2_readdata", csr_readdata, 64'h0);
      chk("rst2_valid", {63'h0, csr_readdata_valid}, 64'h0);
      chk("rst2_ctrl_o", ch_ctrl_o, 64'h0);
      chk("rst2_irq", {62'h0, ch_irq_o}, 64'h0);
      ch_event_i = 16'h0;
      rst_csr = 1'b0;
      idle(1);
      rd(10'h068, 64'h0);
      rd(10'h018, 64'h0);
      rd(10'h058, 64'h0);
      idle(10);
      chk("queue_drained_2", 64'(exp_q.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
